// File: rtl/m_axi_lite_write_seq_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the write sequencer and its slave.
interface m_axi_lite_write_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/m_axi_lite_write_seq.sv
// Round-robin AXI4-Lite write master: one single-beat write per granted requester,
// independent AW/W handshakes, BRESP error reporting and a response timeout.
module m_axi_lite_write_seq #(
  parameter int GLOB_ADDR_WIDTH = 32,
  parameter int GLOB_DATA_WIDTH = 32,
  parameter int NUM_REQ         = 5,
  parameter int REQ_IDX_WIDTH   = 3,
  parameter int TIMEOUT_WIDTH   = 16,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [GLOB_ADDR_WIDTH-1:0]         base_addr,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*GLOB_ADDR_WIDTH-1:0] req_offset,
  input  logic [NUM_REQ*GLOB_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic [NUM_REQ-1:0]                 req_err,
  input  logic [TIMEOUT_WIDTH-1:0]           timeout_cycles,
  output logic                               busy,
  output logic                               timeout_flag,
  output logic [ERR_CNT_WIDTH-1:0]           err_cnt,
  m_axi_lite_write_seq_if.master             axi
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                 state;
  logic [REQ_IDX_WIDTH-1:0]   rr_ptr, gnt, gnt_r;
  logic                       any_req;
  logic [TIMEOUT_WIDTH-1:0]   timer;
  logic [GLOB_ADDR_WIDTH-1:0] awaddr;
  logic [GLOB_DATA_WIDTH-1:0] wdata;
  logic                       awvalid, wvalid, bready;
  logic                       aw_ok, w_ok, tmo_en, tmo_hit;
  logic [NUM_REQ-1:0]         gnt_oh;

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    j       = 0;
    any_req = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_req && req_valid[j]) begin
        any_req = 1'b1;
        gnt     = REQ_IDX_WIDTH'(j);
      end
    end
  end

  // A channel counts as finished if it already handshook or does so this cycle.
  assign aw_ok   = !awvalid || axi.M_AXI_AWREADY;
  assign w_ok    = !wvalid  || axi.M_AXI_WREADY;
  assign tmo_en  = timeout_cycles != '0;
  assign tmo_hit = tmo_en && (timer == timeout_cycles - TIMEOUT_WIDTH'(1));
  assign gnt_oh  = NUM_REQ'(1) << gnt_r;
  assign busy    = state != IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_r        <= '0;
      timer        <= '0;
      awaddr       <= '0;
      wdata        <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      req_done     <= '0;
      req_err      <= '0;
      timeout_flag <= 1'b0;
      err_cnt      <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      case (state)
        IDLE: if (any_req) begin
          gnt_r   <= gnt;
          awaddr  <= base_addr + req_offset[int'(gnt)*GLOB_ADDR_WIDTH +: GLOB_ADDR_WIDTH];
          wdata   <= req_data[int'(gnt)*GLOB_DATA_WIDTH +: GLOB_DATA_WIDTH];
          timer   <= '0;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (tmo_en) timer <= timer + TIMEOUT_WIDTH'(1);
          if (axi.M_AXI_AWREADY) awvalid <= 1'b0;
          if (axi.M_AXI_WREADY)  wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= RESP;
          end else if (tmo_hit) begin
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            timeout_flag <= 1'b1;
            req_done     <= gnt_oh;
            req_err      <= gnt_oh;
            state        <= DONE;
          end
        end
        RESP: begin
          if (tmo_en) timer <= timer + TIMEOUT_WIDTH'(1);
          if (axi.M_AXI_BVALID) begin
            bready   <= 1'b0;
            req_done <= gnt_oh;
            req_err  <= (axi.M_AXI_BRESP != 2'b00) ? gnt_oh : '0;
            state    <= DONE;
          end else if (tmo_hit) begin
            bready       <= 1'b0;
            timeout_flag <= 1'b1;
            req_done     <= gnt_oh;
            req_err      <= gnt_oh;
            state        <= DONE;
          end
        end
        DONE: begin
          if ((|req_err) && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
          if (int'(gnt_r) + 1 >= NUM_REQ) rr_ptr <= '0;
          else                            rr_ptr <= gnt_r + REQ_IDX_WIDTH'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.M_AXI_AWADDR  = awaddr;
  assign axi.M_AXI_AWPROT  = 3'b000;
  assign axi.M_AXI_AWVALID = awvalid;
  assign axi.M_AXI_WDATA   = wdata;
  assign axi.M_AXI_WSTRB   = '1;
  assign axi.M_AXI_WVALID  = wvalid;
  assign axi.M_AXI_BREADY  = bready;

endmodule

// File: tb/tb_m_axi_lite_write_seq.sv
// Directed bench for the AXI4-Lite write sequencer; a second narrow-counter instance
// runs in lockstep to cover error-counter saturation.
module tb_m_axi_lite_write_seq;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  base_addr;
  logic [4:0]   req_valid;
  logic [159:0] req_offset, req_data;
  logic [4:0]   req_done, req_err, req_done2, req_err2;
  logic [15:0]  timeout_cycles;
  logic         busy, timeout_flag, busy2, tflag2;
  logic [7:0]   err_cnt;
  logic [1:0]   err_cnt2;
  int total = 0;
  int bad   = 0;

  m_axi_lite_write_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();
  m_axi_lite_write_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi2 ();

  assign axi2.M_AXI_AWREADY = axi.M_AXI_AWREADY;
  assign axi2.M_AXI_WREADY  = axi.M_AXI_WREADY;
  assign axi2.M_AXI_BRESP   = axi.M_AXI_BRESP;
  assign axi2.M_AXI_BVALID  = axi.M_AXI_BVALID;

  m_axi_lite_write_seq dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .req_valid(req_valid),
    .req_offset(req_offset), .req_data(req_data), .req_done(req_done), .req_err(req_err),
    .timeout_cycles(timeout_cycles), .busy(busy), .timeout_flag(timeout_flag),
    .err_cnt(err_cnt), .axi(axi.master));

  m_axi_lite_write_seq #(.ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .base_addr(base_addr), .req_valid(req_valid),
    .req_offset(req_offset), .req_data(req_data), .req_done(req_done2), .req_err(req_err2),
    .timeout_cycles(timeout_cycles), .busy(busy2), .timeout_flag(tflag2),
    .err_cnt(err_cnt2), .axi(axi2.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr(input int g);
    return (g == 2) ? 32'h4000_0018 : 32'h4000_0000 + 32'h10 * g + 32'h8;
  endfunction

  // Bounded wait for the next done pulse; d stays 0 if none arrives.
  task automatic wait_done(output logic [4:0] d, output logic [4:0] e, output int n);
    d = '0; e = '0; n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (req_done != '0) begin
        d = req_done; e = req_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy, timeout_flag} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b expected 00000",
        {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy, timeout_flag});
    end
    total++;
    if ({req_done, req_err, err_cnt} !== 18'h0) begin
      bad++; $display("FAIL reset_status: got %h expected 0", {req_done, req_err, err_cnt});
    end
    total++;
    if ({axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_AWPROT, axi.M_AXI_WSTRB} !== {64'h0, 3'b000, 4'hF}) begin
      bad++; $display("FAIL reset_bus: got %h %h %b %h expected 0 0 000 f",
        axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_AWPROT, axi.M_AXI_WSTRB);
    end
  endtask

  task automatic test_single();
    req_data[64 +: 32] = 32'hDEAD_BEEF;
    req_valid = 5'b00100;
    tick();
    total++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, busy, axi.M_AXI_BREADY} !== 4'b1110) begin
      bad++; $display("FAIL single_issue: got %b expected 1110",
        {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, busy, axi.M_AXI_BREADY});
    end
    total++;
    if ({axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_WSTRB} !== {32'h4000_0018, 32'hDEAD_BEEF, 4'hF}) begin
      bad++; $display("FAIL single_bus: got %h %h %h expected 40000018 deadbeef f",
        axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_WSTRB);
    end
    tick();
    total++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, req_done} !== {3'b001, 5'b0}) begin
      bad++; $display("FAIL single_resp: got %b expected 00100000",
        {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, req_done});
    end
    tick();
    total++;
    if ({req_done, req_err, axi.M_AXI_BREADY} !== {5'b00100, 5'b0, 1'b0}) begin
      bad++; $display("FAIL single_done: got %b %b %b expected 00100 00000 0",
        req_done, req_err, axi.M_AXI_BREADY);
    end
    req_valid = '0;
    tick();
    total++;
    if ({req_done, busy} !== 6'b0) begin
      bad++; $display("FAIL single_idle: got %b expected 000000", {req_done, busy});
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 4, 0, 1};
    logic [4:0] d, e;
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      wait_done(d, e, n);
      total++;
      if (d !== 5'(1 << order[i]) || n != ((i == 0) ? 3 : 4)) begin
        bad++; $display("FAIL rr_grant%0d: got done=%b after %0d cycles expected %b after %0d",
          i, d, n, 5'(1 << order[i]), (i == 0) ? 3 : 4);
      end
      total++;
      if (axi.M_AXI_AWADDR !== exp_addr(order[i])) begin
        bad++; $display("FAIL rr_addr%0d: got %h expected %h", i, axi.M_AXI_AWADDR, exp_addr(order[i]));
      end
      req_valid[order[i]] = 1'b0;
      if (i == 2) req_valid = 5'b00011;
    end
    tick();
  endtask

  task automatic test_split(input int aw_cyc, input int w_cyc);
    int last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_BVALID = 1'b0;
    req_valid = 5'b01000;
    tick();
    for (int c = 1; c <= last; c++) begin
      total++;
      if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY} !== {c <= aw_cyc, c <= w_cyc, 1'b0}
          || axi.M_AXI_AWADDR !== exp_addr(3)) begin
        bad++; $display("FAIL split_aw%0d_w%0d_c%0d: got %b addr %h expected %b addr %h", aw_cyc, w_cyc, c,
          {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}, axi.M_AXI_AWADDR,
          {c <= aw_cyc, c <= w_cyc, 1'b0}, exp_addr(3));
      end
      axi.M_AXI_AWREADY = (c == aw_cyc);
      axi.M_AXI_WREADY  = (c == w_cyc);
      tick();
    end
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    total++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, req_done} !== {3'b001, 5'b0}) begin
      bad++; $display("FAIL split_resp_aw%0d_w%0d: got %b expected 00100000", aw_cyc, w_cyc,
        {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, req_done});
    end
    axi.M_AXI_BVALID = 1'b1;
    tick();
    req_valid = '0;
    total++;
    if ({req_done, axi.M_AXI_BREADY} !== {5'b01000, 1'b0}) begin
      bad++; $display("FAIL split_done_aw%0d_w%0d: got %b expected 010000", aw_cyc, w_cyc,
        {req_done, axi.M_AXI_BREADY});
    end
    tick();
    total++;
    if ({axi.M_AXI_BREADY, busy} !== 2'b00) begin
      bad++; $display("FAIL split_idle_aw%0d_w%0d: got %b expected 00", aw_cyc, w_cyc,
        {axi.M_AXI_BREADY, busy});
    end
    axi.M_AXI_AWREADY = 1'b1; axi.M_AXI_WREADY = 1'b1;
  endtask

  task automatic test_error();
    logic [1:0] tbl [5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [4:0] d, e;
    int n;
    for (int i = 0; i < 5; i++) begin
      axi.M_AXI_BRESP = tbl[i];
      req_valid = 5'b00010;
      wait_done(d, e, n);
      total++;
      if (d !== 5'b00010 || e !== 5'b00010) begin
        bad++; $display("FAIL err_resp%0d: got done=%b err=%b expected 00010 00010", i, d, e);
      end
      req_valid = '0;
      tick();
      if (i == 1) begin
        total++;
        if (err_cnt !== 8'd2) begin
          bad++; $display("FAIL err_cnt2: got %0d expected 2", err_cnt);
        end
      end
    end
    total++;
    if (err_cnt !== 8'd5 || err_cnt2 !== 2'd3) begin
      bad++; $display("FAIL err_cnt5: got %0d/%0d expected 5/3", err_cnt, err_cnt2);
    end
    axi.M_AXI_BRESP = 2'b00;
    req_valid = 5'b00010;
    wait_done(d, e, n);
    req_valid = '0;
    tick();
    total++;
    if (d !== 5'b00010 || e !== 5'b0 || err_cnt !== 8'd5 || err_cnt2 !== 2'd3) begin
      bad++; $display("FAIL err_okay: got done=%b err=%b cnt=%0d/%0d expected 00010 00000 5/3",
        d, e, err_cnt, err_cnt2);
    end
    total++;
    if ({req_done2, req_err2, busy2, tflag2, axi2.M_AXI_AWVALID, axi2.M_AXI_WVALID, axi2.M_AXI_BREADY,
         axi2.M_AXI_AWADDR, axi2.M_AXI_WDATA, axi2.M_AXI_AWPROT, axi2.M_AXI_WSTRB}
        !== {15'b0, exp_addr(1), 32'hA000_0001, 3'b000, 4'hF}) begin
      bad++; $display("FAIL narrow_idle: got %b %h %h expected all-zero ctrl %h a0000001",
        {req_done2, req_err2, busy2, tflag2, axi2.M_AXI_AWVALID, axi2.M_AXI_WVALID, axi2.M_AXI_BREADY},
        axi2.M_AXI_AWADDR, axi2.M_AXI_WDATA, exp_addr(1));
    end
  endtask

  task automatic test_timeout();
    logic [4:0] d, e;
    logic lastb, saw;
    int n;
    // Handshake on the final timer cycle must win over the timeout.
    timeout_cycles = 16'd2; axi.M_AXI_BVALID = 1'b0;
    req_valid = 5'b01000;
    tick(); tick();
    axi.M_AXI_BVALID = 1'b1;
    tick();
    total++;
    if ({req_done, req_err, timeout_flag} !== {5'b01000, 5'b0, 1'b0}) begin
      bad++; $display("FAIL tmo_edge: got %b %b %b expected 01000 00000 0", req_done, req_err, timeout_flag);
    end
    req_valid = '0; axi.M_AXI_BVALID = 1'b0;
    tick();
    timeout_cycles = 16'd8;
    req_valid = 5'b01000;
    tick();
    n = 0; lastb = 1'b0;
    for (int i = 0; i < 30 && req_done == '0; i++) begin
      n++; lastb = axi.M_AXI_BREADY;
      tick();
    end
    total++;
    if (n != 8 || lastb !== 1'b1 || axi.M_AXI_BREADY !== 1'b0) begin
      bad++; $display("FAIL tmo_len: got %0d cycles lastb=%b bready=%b expected 8 1 0", n, lastb, axi.M_AXI_BREADY);
    end
    total++;
    if ({req_done, req_err, timeout_flag} !== {5'b01000, 5'b01000, 1'b1}) begin
      bad++; $display("FAIL tmo_err: got %b %b %b expected 01000 01000 1", req_done, req_err, timeout_flag);
    end
    req_valid = '0;
    tick();
    axi.M_AXI_BVALID = 1'b1;
    req_valid = 5'b01000;
    wait_done(d, e, n);
    req_valid = '0;
    tick();
    total++;
    if (d !== 5'b01000 || e !== 5'b0 || timeout_flag !== 1'b1) begin
      bad++; $display("FAIL tmo_sticky: got done=%b err=%b flag=%b expected 01000 00000 1", d, e, timeout_flag);
    end
    timeout_cycles = 16'd0; axi.M_AXI_BVALID = 1'b0;
    req_valid = 5'b01000;
    saw = 1'b0;
    repeat (1000) begin
      tick();
      saw |= |req_done;
    end
    total++;
    if ({saw, busy, axi.M_AXI_BREADY} !== 3'b011) begin
      bad++; $display("FAIL tmo_disabled: got %b expected 011", {saw, busy, axi.M_AXI_BREADY});
    end
    axi.M_AXI_BVALID = 1'b1;
    wait_done(d, e, n);
    req_valid = '0;
    tick();
    total++;
    if (d !== 5'b01000 || e !== 5'b0) begin
      bad++; $display("FAIL tmo_disabled_done: got %b %b expected 01000 00000", d, e);
    end
  endtask

  task automatic test_reset_midop();
    logic [4:0] d, e;
    int n;
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    req_valid = 5'b01000;
    tick(); tick();
    total++;
    if ({axi.M_AXI_AWVALID, busy} !== 2'b11) begin
      bad++; $display("FAIL midop_pre: got %b expected 11", {axi.M_AXI_AWVALID, busy});
    end
    reset = 1'b1;
    tick();
    total++;
    if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy, req_done, err_cnt, timeout_flag} !== 18'b0) begin
      bad++; $display("FAIL midop_reset: got %b expected 0",
        {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy, req_done, err_cnt, timeout_flag});
    end
    reset = 1'b0;
    axi.M_AXI_AWREADY = 1'b1; axi.M_AXI_WREADY = 1'b1;
    req_valid = 5'b10010;
    wait_done(d, e, n);
    total++;
    if (d !== 5'b00010 || e !== 5'b0 || n != 3 || axi.M_AXI_AWADDR !== exp_addr(1)) begin
      bad++; $display("FAIL midop_after: got done=%b err=%b n=%0d addr=%h expected 00010 00000 3 %h",
        d, e, n, axi.M_AXI_AWADDR, exp_addr(1));
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    base_addr = 32'h4000_0000;
    req_valid = '0;
    timeout_cycles = '0;
    for (int i = 0; i < 5; i++) begin
      req_offset[i*32 +: 32] = (i == 2) ? 32'h18 : 32'h10 * i + 32'h8;
      req_data[i*32 +: 32]   = 32'hA000_0000 + i;
    end
    axi.M_AXI_AWREADY = 1'b1;
    axi.M_AXI_WREADY  = 1'b1;
    axi.M_AXI_BVALID  = 1'b1;
    axi.M_AXI_BRESP   = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_split(4, 1);
    test_split(1, 4);
    test_split(2, 2);
    test_error();
    test_timeout();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
